rpn_engine: RTL and testbench

//  Parametrised RPN stack-calculator core; successor to the fixed 32-bit button-driven calculator.

---
 rtl/rpn_engine_if.sv | 26 ++
 rtl/rpn_engine.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_rpn_engine.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_engine_if.sv
// Command channel of the RPN engine.
// The master (button decoder or UART parser) drives cmd_valid, cmd_op and cmd_data.
// The slave (rpn_engine) drives cmd_ready.
// A command is taken on any rising clock edge where cmd_valid && cmd_ready.
interface rpn_engine_if #(
  parameter int WIDTH = 32
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/rpn_engine.sv
// rpn_engine: parametrised RPN stack-calculator core.
// The engine holds its own stack and executes one opcode per accepted command.
// DIV and MOD run on a restoring divider that produces one quotient bit per cycle.
// Every other opcode completes in a single cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   cmd       command channel (valid/ready/op/data, slave side)
//   top       stack[size-1], or 0 when the stack is empty
//   second    stack[size-2], or 0 when size < 2
//   size      number of words on the stack
//   empty     high when size == 0
//   error     high when err_code != 0 (sticky)
//   err_code  first error since the last clear:
//             0 none, 1 underflow, 2 overflow, 3 divide by zero, 4 illegal opcode
//
// FSM states:
//   state    | meaning
//   S_IDLE   | accepting commands, single-cycle ops execute here
//   S_DIVIDE | restoring divider iterating, one quotient bit per cycle
//   S_WB     | divider result replaces the two operands on the stack
module rpn_engine #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 64,
  parameter int APPEND_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  rpn_engine_if.slave                cmd,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           second,
  output logic [$clog2(DEPTH+1)-1:0] size,
  output logic                       empty,
  output logic                       error,
  output logic [2:0]                 err_code
);
  localparam int SW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [3:0] OP_PUSH   = 4'd0;
  localparam logic [3:0] OP_APPEND = 4'd1;
  localparam logic [3:0] OP_ADD    = 4'd2;
  localparam logic [3:0] OP_SUB    = 4'd3;
  localparam logic [3:0] OP_MUL    = 4'd4;
  localparam logic [3:0] OP_DIV    = 4'd5;
  localparam logic [3:0] OP_MOD    = 4'd6;
  localparam logic [3:0] OP_POP    = 4'd7;
  localparam logic [3:0] OP_DUP    = 4'd8;
  localparam logic [3:0] OP_SWAP   = 4'd9;
  localparam logic [3:0] OP_CLEAR  = 4'd10;
  localparam logic [3:0] OP_CLRERR = 4'd11;

  localparam logic [2:0] ERR_UNDER   = 3'd1;
  localparam logic [2:0] ERR_OVER    = 3'd2;
  localparam logic [2:0] ERR_DIV0    = 3'd3;
  localparam logic [2:0] ERR_ILLEGAL = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_WB     = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [SW-1:0]    size_q, size_d, size_m1, size_p1;
  logic [AW-1:0]    idx_top, idx_sec, idx_new;
  logic             has1, has2, full, accept;
  logic [WIDTH-1:0] opa, opb, alu_res;
  logic [2:0]       err_q, err_cause;
  logic             err_clr;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_idx, wr1_idx;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  logic             div_start, div_mod_q;
  logic [WIDTH-1:0] quot_q, rem_q, den_q, rem_diff;
  logic [WIDTH:0]   rem_shift;
  logic             rem_ge;
  logic [CW-1:0]    cnt_q;

  // Stack pointers and operand views
  assign size_m1 = size_q - SW'(1);
  assign size_p1 = size_q + SW'(1);
  assign idx_top = AW'(size_q - SW'(1));
  assign idx_sec = AW'(size_q - SW'(2));
  assign idx_new = AW'(size_q);
  assign has1    = (size_q != '0);
  assign has2    = (size_q >= SW'(2));
  assign full    = (size_q == SW'(DEPTH));
  assign opb     = has1 ? mem[idx_top] : '0;
  assign opa     = has2 ? mem[idx_sec] : '0;
  assign accept  = cmd.cmd_valid && cmd.cmd_ready;

  always_comb begin
    alu_res = opa * opb;
    if (cmd.cmd_op == OP_ADD) begin
      alu_res = opa + opb;
    end else if (cmd.cmd_op == OP_SUB) begin
      alu_res = opa - opb;
    end
  end

  // One restoring-division step: shift in the next dividend bit and subtract if it fits.
  // The partial remainder is always below the divisor, so the difference fits in WIDTH bits.
  assign rem_shift = {rem_q, quot_q[WIDTH-1]};
  assign rem_ge    = (rem_shift >= {1'b0, den_q});
  assign rem_diff  = rem_shift[WIDTH-1:0] - den_q;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (div_start) state_d = S_DIVIDE;
      S_DIVIDE: if (cnt_q == '0) state_d = S_WB;
      S_WB:     state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd.cmd_ready = (state_q == S_IDLE);
  end

  // Command execution.
  // A failing command issues no writes and keeps its size, so the stack stays bit-identical.
  always_comb begin
    wr0_en    = 1'b0;
    wr0_idx   = idx_new;
    wr0_data  = cmd.cmd_data;
    wr1_en    = 1'b0;
    wr1_idx   = idx_top;
    wr1_data  = opa;
    size_d    = size_q;
    err_cause = 3'd0;
    err_clr   = 1'b0;
    div_start = 1'b0;
    if (state_q == S_WB) begin
      wr0_en   = 1'b1;
      wr0_idx  = idx_sec;
      wr0_data = div_mod_q ? rem_q : quot_q;
      size_d   = size_m1;
    end else if (accept) begin
      case (cmd.cmd_op)
        OP_PUSH: begin
          if (full) begin
            err_cause = ERR_OVER;
          end else begin
            wr0_en = 1'b1;
            size_d = size_p1;
          end
        end
        OP_APPEND: begin
          wr0_en = 1'b1;
          if (!has1) begin
            wr0_data = {{(WIDTH-APPEND_BITS){1'b0}}, cmd.cmd_data[APPEND_BITS-1:0]};
            size_d   = size_p1;
          end else begin
            wr0_idx  = idx_top;
            wr0_data = {opb[WIDTH-APPEND_BITS-1:0], cmd.cmd_data[APPEND_BITS-1:0]};
          end
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (!has2) begin
            err_cause = ERR_UNDER;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_sec;
            wr0_data = alu_res;
            size_d   = size_m1;
          end
        end
        OP_DIV, OP_MOD: begin
          if (!has2) begin
            err_cause = ERR_UNDER;
          end else if (opb == '0) begin
            err_cause = ERR_DIV0;
          end else begin
            div_start = 1'b1;
          end
        end
        OP_POP: begin
          if (!has1) begin
            err_cause = ERR_UNDER;
          end else begin
            size_d = size_m1;
          end
        end
        OP_DUP: begin
          if (!has1) begin
            err_cause = ERR_UNDER;
          end else if (full) begin
            err_cause = ERR_OVER;
          end else begin
            wr0_en   = 1'b1;
            wr0_data = opb;
            size_d   = size_p1;
          end
        end
        OP_SWAP: begin
          if (!has2) begin
            err_cause = ERR_UNDER;
          end else begin
            wr0_en   = 1'b1;
            wr0_idx  = idx_sec;
            wr0_data = opb;
            wr1_en   = 1'b1;
          end
        end
        OP_CLEAR: begin
          size_d  = '0;
          err_clr = 1'b1;
        end
        OP_CLRERR: err_clr = 1'b1;
        default:   err_cause = ERR_ILLEGAL;
      endcase
    end
  end

  // Stack storage needs no reset: size alone decides which words are visible.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr0_idx] <= wr0_data;
    if (wr1_en) mem[wr1_idx] <= wr1_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q <= '0;
      err_q  <= 3'd0;
    end else begin
      size_q <= size_d;
      if (err_clr) begin
        err_q <= 3'd0;
      end else if (err_q == 3'd0 && err_cause != 3'd0) begin
        err_q <= err_cause;
      end
    end
  end

  // The operands stay on the stack during the division, so no command can disturb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      quot_q    <= '0;
      rem_q     <= '0;
      den_q     <= '0;
      cnt_q     <= '0;
      div_mod_q <= 1'b0;
    end else if (div_start) begin
      quot_q    <= opa;
      rem_q     <= '0;
      den_q     <= opb;
      cnt_q     <= CW'(WIDTH - 1);
      div_mod_q <= (cmd.cmd_op == OP_MOD);
    end else if (state_q == S_DIVIDE) begin
      rem_q  <= rem_ge ? rem_diff : rem_shift[WIDTH-1:0];
      quot_q <= {quot_q[WIDTH-2:0], rem_ge};
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  assign top      = opb;
  assign second   = opa;
  assign size     = size_q;
  assign empty    = ~has1;
  assign err_code = err_q;
  assign error    = (err_q != 3'd0);

endmodule

// File: tb/tb_rpn_engine.sv
module tb_rpn_engine;
  localparam int WIDTH       = 32;
  localparam int DEPTH       = 64;
  localparam int APPEND_BITS = 8;
  localparam int SW          = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] top, second;
  logic [SW-1:0]    size;
  logic             empty, error;
  logic [2:0]       err_code;

  int checks = 0;
  int errors = 0;

  // Reference model: the stack is a queue whose last element is the top.
  logic [WIDTH-1:0] stk [$];
  logic [2:0]       m_err;

  rpn_engine_if #(.WIDTH(WIDTH)) cmd_if ();

  rpn_engine #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .APPEND_BITS(APPEND_BITS)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cmd     (cmd_if.slave),
    .top     (top),
    .second  (second),
    .size    (size),
    .empty   (empty),
    .error   (error),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_err(input logic [2:0] c);
    if (m_err == 3'd0) m_err = c;
  endtask

  task automatic model_apply(input logic [3:0] op, input logic [WIDTH-1:0] d, output int busy);
    int n;
    logic [WIDTH-1:0] a, b, res, lowmask;
    n       = stk.size();
    b       = (n >= 1) ? stk[n-1] : '0;
    a       = (n >= 2) ? stk[n-2] : '0;
    lowmask = (WIDTH'(1) << APPEND_BITS) - WIDTH'(1);
    busy    = 0;
    res     = '0;
    case (op)
      4'd0: if (n == DEPTH) set_err(3'd2); else stk.push_back(d);
      4'd1: if (n == 0) stk.push_back(d & lowmask); else stk[n-1] = (b << APPEND_BITS) | (d & lowmask);
      4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
        if (n < 2) begin
          set_err(3'd1);
        end else if ((op == 4'd5 || op == 4'd6) && b == '0) begin
          set_err(3'd3);
        end else begin
          case (op)
            4'd2:    res = a + b;
            4'd3:    res = a - b;
            4'd4:    res = a * b;
            4'd5:    res = a / b;
            default: res = a % b;
          endcase
          if (op == 4'd5 || op == 4'd6) busy = WIDTH + 1;
          void'(stk.pop_back());
          void'(stk.pop_back());
          stk.push_back(res);
        end
      end
      4'd7: if (n == 0) set_err(3'd1); else void'(stk.pop_back());
      4'd8: begin
        if (n == 0) set_err(3'd1);
        else if (n == DEPTH) set_err(3'd2);
        else stk.push_back(b);
      end
      4'd9: begin
        if (n < 2) set_err(3'd1);
        else begin
          stk[n-1] = a;
          stk[n-2] = b;
        end
      end
      4'd10: begin
        stk.delete();
        m_err = 3'd0;
      end
      4'd11: m_err = 3'd0;
      default: set_err(3'd4);
    endcase
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = stk.size();
    chk({tag, " size"},     64'(size),     64'(n));
    chk({tag, " top"},      64'(top),      (n >= 1) ? 64'(stk[n-1]) : 64'd0);
    chk({tag, " second"},   64'(second),   (n >= 2) ? 64'(stk[n-2]) : 64'd0);
    chk({tag, " empty"},    64'(empty),    64'(n == 0));
    chk({tag, " err_code"}, 64'(err_code), 64'(m_err));
    chk({tag, " error"},    64'(error),    64'(m_err != 3'd0));
  endtask

  // Called at a falling edge with cmd_ready high; returns at a falling edge with cmd_ready high.
  // While the engine is busy the bench keeps offering junk PUSHes, which must be ignored.
  task automatic send(input logic [3:0] op, input logic [WIDTH-1:0] d, input string tag);
    int exp_busy, busy;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    model_apply(op, d, exp_busy);
    @(posedge clk);
    @(negedge clk);
    busy = 0;
    while (!cmd_if.cmd_ready && busy < 200) begin
      busy++;
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 4'd0;
      cmd_if.cmd_data  = $urandom;
      @(negedge clk);
    end
    cmd_if.cmd_valid = 1'b0;
    chk({tag, " busy_cycles"}, 64'(busy), 64'(exp_busy));
    check_outputs(tag);
  endtask

  initial begin
    int r;
    logic [3:0]       op;
    logic [WIDTH-1:0] d;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 4'd0;
    cmd_if.cmd_data  = '0;
    m_err            = 3'd0;
    reset_n          = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs("reset");
    chk("reset ready", 64'(cmd_if.cmd_ready), 64'd1);
    reset_n = 1'b1;
    @(negedge clk);

    // Subtraction, including wrap-around
    send(4'd0, 32'd7, "push7");
    send(4'd0, 32'd5, "push5");
    send(4'd3, '0, "sub");
    chk("sub result", 64'(top), 64'd2);
    send(4'd0, 32'd5, "push5b");
    send(4'd3, '0, "sub_wrap");
    chk("sub wrap result", 64'(top), 64'hFFFF_FFFD);

    // Division and modulo
    send(4'd10, '0, "clear0");
    send(4'd0, 32'd100, "push100");
    send(4'd0, 32'd7, "push7b");
    send(4'd5, '0, "div");
    chk("div result", 64'(top), 64'd14);
    send(4'd10, '0, "clear1");
    send(4'd0, 32'd100, "push100b");
    send(4'd0, 32'd7, "push7c");
    send(4'd6, '0, "mod");
    chk("mod result", 64'(top), 64'd2);

    // Divide by zero
    send(4'd10, '0, "clear2");
    send(4'd0, 32'd9, "push9");
    send(4'd0, 32'd0, "push0");
    send(4'd5, '0, "div0");
    chk("div0 err_code", 64'(err_code), 64'd3);
    chk("div0 second", 64'(second), 64'd9);

    // Overflow, then underflow, then clear of the error
    send(4'd10, '0, "clear3");
    for (int i = 0; i <= DEPTH; i++) send(4'd0, WIDTH'(i + 1), "fill");
    chk("overflow size", 64'(size), 64'(DEPTH));
    chk("overflow err_code", 64'(err_code), 64'd2);
    send(4'd8, '0, "dup_full");
    send(4'd10, '0, "clear4");
    send(4'd2, '0, "add_empty");
    chk("underflow err_code", 64'(err_code), 64'd1);
    send(4'd11, '0, "clrerr");
    chk("clrerr err_code", 64'(err_code), 64'd0);

    // APPEND chain and SWAP underflow
    send(4'd0, 32'h12, "push12");
    send(4'd1, 32'hAB34, "append34");
    send(4'd1, 32'h56, "append56");
    chk("append result", 64'(top), 64'h12_3456);
    send(4'd9, '0, "swap_one");
    chk("swap underflow err_code", 64'(err_code), 64'd1);
    chk("swap underflow top", 64'(top), 64'h12_3456);
    send(4'd10, '0, "clear5");
    send(4'd1, 32'h1FF, "append_empty");

    // Reset in the middle of a division
    send(4'd0, 32'd100, "push100c");
    send(4'd0, 32'd7, "push7d");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-div ready", 64'(cmd_if.cmd_ready), 64'd0);
    reset_n = 1'b0;
    #1;
    chk("reset mid-div size", 64'(size), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stk.delete();
    m_err = 3'd0;
    @(negedge clk);
    chk("post-reset ready", 64'(cmd_if.cmd_ready), 64'd1);
    check_outputs("post-reset");
    send(4'd13, '0, "illegal");
    chk("illegal err_code", 64'(err_code), 64'd4);

    // Randomised command stream against the model
    send(4'd10, '0, "clear_rand");
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 35)      op = 4'd0;
      else if (r < 42) op = 4'd1;
      else             op = 4'($urandom_range(2, 15));
      d = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 3)) : WIDTH'($urandom);
      send(op, d, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
